parity_scan_arbiter: RTL and testbench
======================================

Name: parity_scan_arbiter

Overview:
- Shares one serial even/odd 0s/1s parity checker among NUM_REQ requesters.
- Arbitrates round-robin between requesters and captures the winner's DATA_W-bit word.
- Serializes the word LSB-first on bit_out/bit_valid and tracks zero-count and one-count parity internally.
- Reports even_0s/even_1s, tagged with the requester id, on a one-cycle done pulse.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, word width per requester (>=1)
- ID_W, 2, width of done_id; must satisfy 2**ID_W >= NUM_REQ

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request level; hold until gnt
- data_flat  input  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]; stable while req[i]=1
- gnt  output  NUM_REQ  one-hot, one-cycle grant pulse
- busy  output  1  high when state is not IDLE
- bit_out  output  1  current serialized bit
- bit_valid  output  1  bit_out qualifier
- done  output  1  one-cycle result pulse
- done_id  output  ID_W  index of the requester whose result is reported
- even_0s  output  1  1 = even number of 0s in the last completed word
- even_1s  output  1  1 = even number of 1s in the last completed word

Behaviour:
- Reset values (asynchronous): state=IDLE, gnt=0, busy=0, bit_valid=0, bit_out=0, done=0, done_id=0, even_0s=1, even_1s=1 (zero count is even). RR pointer last=NUM_REQ-1, so req[0] has highest priority first.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on the edge where req!=0:
  - Select the first set req index scanning upward from last+1 (mod NUM_REQ).
  - Load the shift register from that requester's slice; last<=winner; id register<=winner.
  - Bit counter<=0; internal parity flags p0<=1, p1<=1; gnt<=onehot(winner); state<=SHIFT.
- SHIFT (exactly DATA_W cycles):
  - bit_valid=1 and bit_out=shreg[0] for the whole state.
  - Each edge: shift right; toggle p1 if bit=1, else toggle p0; counter++.
  - gnt is high only in the first SHIFT cycle.
  - On the edge consuming bit DATA_W-1: latch even_0s<=final p0, even_1s<=final p1, done_id<=id; done<=1; state<=DONE.
- DONE (1 cycle): done=1, busy=1; then IDLE. Requests are not sampled in DONE.
- Timing, relative to the IDLE capture edge E0:
  - gnt in cycle 1.
  - bits in cycles 1..DATA_W.
  - done in cycle DATA_W+1.
  - IDLE in cycle DATA_W+2.
  - Back-to-back frame period is DATA_W+2 cycles.
- even_0s/even_1s/done_id hold their values between done pulses.
- req deassertion or data change after E0 is ignored; the frame completes from the captured word.
- Simultaneous requests: exactly one winner per IDLE decision; losers stay pending.
- A requester whose req stays asserted after gnt is treated as a new request at the next IDLE, subject to RR order.
- Reset mid-frame: immediate abort to reset values, no done pulse, RR pointer returns to NUM_REQ-1.
- Parity arithmetic is 1-bit toggle only; there are no counters wider than $clog2(DATA_W+1) for the bit index.

Test Plan:
- reset, req=0001, word0=8'h00 -> gnt=0001 one cycle; bit_out 0 for 8 cycles; done in cycle 9 with done_id=0, even_0s=1, even_1s=1.
- req=0100, word2=8'h0B -> serial stream 1,1,0,1,0,0,0,0; done_id=2, even_0s=0, even_1s=0.
- DATA_W=5 override, req[1] with 5'b00011 -> done_id=1, even_1s=1, even_0s=0.
- req=1111 held continuously -> grant order 0,1,2,3,0; consecutive gnt pulses 10 cycles apart; each done_id matches the preceding grant.
- req[3] with 8'hFF, assert reset in 4th SHIFT cycle -> no done; outputs return to reset values; after release with req=1000 -> done_id=3, even_0s=1, even_1s=1.
- req[0] dropped and word0 changed one cycle after gnt -> done reports parity of the originally captured word.

Source files
------------

// File: rtl/parity_scan_arbiter_if.sv
// Requester-side bus of the shared parity scanner: request/data going in,
// grant, serial bit stream and parity result coming back.
interface parity_scan_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] data_flat;
   logic [NUM_REQ-1:0]        gnt;
   logic                      busy;
   logic                      bit_out;
   logic                      bit_valid;
   logic                      done;
   logic [ID_W-1:0]           done_id;
   logic                      even_0s;
   logic                      even_1s;

   // Requester side: drives requests and words, observes the scanner
   modport master (
      output req, data_flat,
      input  gnt, busy, bit_out, bit_valid, done, done_id, even_0s, even_1s
   );

   // Scanner side: samples requests and words, reports grant/stream/result
   modport slave (
      input  req, data_flat,
      output gnt, busy, bit_out, bit_valid, done, done_id, even_0s, even_1s
   );
endinterface

// File: rtl/parity_scan_arbiter.sv
// Round-robin shared serial parity checker. One requester word is captured
// per frame, shifted out LSB-first, and the even-zeros / even-ones flags are
// reported with the requester id on a one-cycle done pulse.
module parity_scan_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
) (
   input logic                    clk,
   input logic                    reset,
   parity_scan_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam logic [ID_W-1:0]  LAST_RESET = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                p0_q, p0_d;
   logic                p1_q, p1_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic                even0_q, even0_d;
   logic                even1_q, even1_d;

   logic                found;
   logic [ID_W-1:0]     winner;
   logic [DATA_W-1:0]   win_word;

   // Round-robin pick: scan upward starting just after the previous winner
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      win_word = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[i] && (((int'(last_q) + k) % NUM_REQ) == i)) begin
               found    = 1'b1;
               winner   = ID_W'(i);
               win_word = bus.data_flat[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Frame sequencing: capture in IDLE, shift and fold parity, then report
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      p0_d      = p0_q;
      p1_d      = p1_q;
      last_d    = last_q;
      id_d      = id_q;
      done_id_d = done_id_q;
      even0_d   = even0_q;
      even1_d   = even1_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               shreg_d = win_word;
               last_d  = winner;
               id_d    = winner;
               cnt_d   = '0;
               p0_d    = 1'b1;
               p1_d    = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d = shreg_q >> 1;
            p1_d    = p1_q ^ shreg_q[0];
            p0_d    = p0_q ^ ~shreg_q[0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               even0_d   = p0_d;
               even1_d   = p1_d;
               done_id_d = id_q;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         cnt_q     <= '0;
         p0_q      <= 1'b1;
         p1_q      <= 1'b1;
         last_q    <= LAST_RESET;
         id_q      <= '0;
         done_id_q <= '0;
         even0_q   <= 1'b1;
         even1_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         p0_q      <= p0_d;
         p1_q      <= p1_d;
         last_q    <= last_d;
         id_q      <= id_d;
         done_id_q <= done_id_d;
         even0_q   <= even0_d;
         even1_q   <= even1_d;
      end
   end

   // Grant is only shown in the first shift cycle of a frame
   assign bus.gnt       = (state_q == SHIFT && cnt_q == '0) ? (NUM_REQ'(1) << id_q) : '0;
   assign bus.busy      = (state_q != IDLE);
   assign bus.bit_valid = (state_q == SHIFT);
   assign bus.bit_out   = (state_q == SHIFT) & shreg_q[0];
   assign bus.done      = (state_q == DONE);
   assign bus.done_id   = done_id_q;
   assign bus.even_0s   = even0_q;
   assign bus.even_1s   = even1_q;

endmodule

// File: tb/tb_parity_scan_arbiter.sv
// Scoreboard bench for parity_scan_arbiter: a driver predicts each frame from
// round-robin rules and pushes it; a monitor pops and checks grant, stream and
// result as the DUT presents them.
module tb_parity_scan_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int ID_W    = 2;
   localparam int FW      = NUM_REQ * DATA_W;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   parity_scan_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) tbIf();

   parity_scan_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tbIf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to timestamp grants and done pulses
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                id;
      logic [DATA_W-1:0] word;
      int                gntCyc;
   } exp_t;

   exp_t              expQ[$];
   int                modelLast   = NUM_REQ - 1;
   int                modelBusy   = 0;
   logic [NUM_REQ-1:0] reqV       = '0;
   logic [FW-1:0]     dataV       = '0;
   logic              capturedNow = 1'b0;
   int                capWinner   = 0;
   logic              monActive   = 1'b0;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] getWord(input logic [FW-1:0] d, input int i);
      logic [FW-1:0] t;
      t = d >> (i * DATA_W);
      return t[DATA_W-1:0];
   endfunction

   function automatic logic [FW-1:0] setWord(input logic [FW-1:0] d, input int i,
                                             input logic [DATA_W-1:0] w);
      logic [FW-1:0] m;
      logic [FW-1:0] v;
      m = FW'({DATA_W{1'b1}}) << (i * DATA_W);
      v = FW'(w) << (i * DATA_W);
      return (d & ~m) | v;
   endfunction

   // Reference arbitration: first requester after the last winner, cyclically
   function automatic int pickWinner(input logic [NUM_REQ-1:0] r, input int last);
      logic [NUM_REQ-1:0] t;
      int i;
      for (int k = 1; k <= NUM_REQ; k++) begin
         i = (last + k) % NUM_REQ;
         t = r >> i;
         if (t[0]) return i;
      end
      return -1;
   endfunction

   // Drive one cycle; predict whether the coming edge starts a frame
   task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [FW-1:0] d);
      int w;
      tbIf.req       = r;
      tbIf.data_flat = d;
      capturedNow    = 1'b0;
      if (modelBusy == 0 && r != '0) begin
         w = pickWinner(r, modelLast);
         expQ.push_back('{id: w, word: getWord(d, w), gntCyc: cyc + 1});
         modelLast   = w;
         modelBusy   = DATA_W + 1;
         capturedNow = 1'b1;
         capWinner   = w;
      end else if (modelBusy > 0) begin
         modelBusy--;
      end
      @(posedge clk);
      #2;
      checkOutput("busy", int'(tbIf.busy), (modelBusy != 0) ? 1 : 0);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      expQ.delete();
      modelBusy      = 0;
      modelLast      = NUM_REQ - 1;
      reqV           = '0;
      tbIf.req       = '0;
      #1;
      checkOutput("rst_gnt",       int'(tbIf.gnt),       0);
      checkOutput("rst_busy",      int'(tbIf.busy),      0);
      checkOutput("rst_bit_valid", int'(tbIf.bit_valid), 0);
      checkOutput("rst_bit_out",   int'(tbIf.bit_out),   0);
      checkOutput("rst_done",      int'(tbIf.done),      0);
      checkOutput("rst_done_id",   int'(tbIf.done_id),   0);
      checkOutput("rst_even_0s",   int'(tbIf.even_0s),   1);
      checkOutput("rst_even_1s",   int'(tbIf.even_1s),   1);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && (expQ.size() != 0 || monActive || modelBusy != 0); t++)
         applyStimulus('0, dataV);
      checkOutput("drain_pending", expQ.size() + (monActive ? 1 : 0), 0);
   endtask

   // Monitor: pop an expected frame on each grant and check it through done
   initial begin
      exp_t              cur;
      int                bitIdx;
      int                heldId;
      int                held0;
      int                held1;
      logic [DATA_W-1:0] t;
      cur    = '{id: 0, word: '0, gntCyc: 0};
      bitIdx = 0;
      heldId = 0;
      held0  = 1;
      held1  = 1;
      forever begin
         @(negedge clk);
         if (reset) begin
            monActive = 1'b0;
            heldId    = 0;
            held0     = 1;
            held1     = 1;
            continue;
         end
         if (tbIf.gnt != '0) begin
            if (monActive)
               checkOutput("gnt_midframe", int'(tbIf.gnt), 0);
            else if (expQ.size() == 0)
               checkOutput("gnt_unexpected", int'(tbIf.gnt), 0);
            else begin
               cur = expQ.pop_front();
               checkOutput("gnt_onehot", int'(tbIf.gnt), 1 << cur.id);
               checkOutput("gnt_cycle", cyc, cur.gntCyc);
               monActive = 1'b1;
               bitIdx    = 0;
            end
         end
         if (tbIf.bit_valid) begin
            if (!monActive || bitIdx >= DATA_W)
               checkOutput("bit_valid_unexpected", 1, 0);
            else begin
               t = cur.word >> bitIdx;
               checkOutput($sformatf("bit%0d_id%0d", bitIdx, cur.id), int'(tbIf.bit_out), int'(t[0]));
               bitIdx++;
            end
         end
         if (tbIf.done) begin
            if (!monActive)
               checkOutput("done_unexpected", 1, 0);
            else begin
               checkOutput("done_cycle", cyc, cur.gntCyc + DATA_W);
               heldId    = cur.id;
               held0     = (((DATA_W - $countones(cur.word)) % 2) == 0) ? 1 : 0;
               held1     = (($countones(cur.word) % 2) == 0) ? 1 : 0;
               monActive = 1'b0;
            end
         end
         checkOutput("done_id", int'(tbIf.done_id), heldId);
         checkOutput("even_0s", int'(tbIf.even_0s), held0);
         checkOutput("even_1s", int'(tbIf.even_1s), held1);
      end
   end

   // Driver: directed frames from the test plan, then randomized traffic
   initial begin
      logic [NUM_REQ-1:0] t;
      tbIf.req       = '0;
      tbIf.data_flat = '0;
      @(posedge clk);
      #2;
      resetDut();

      // Requester 0 with an all-zero word
      dataV = setWord('0, 0, 8'h00);
      applyStimulus(4'b0001, dataV);
      drain();

      // Requester 2 with 0x0B
      dataV = setWord(dataV, 2, 8'h0B);
      applyStimulus(4'b0100, dataV);
      drain();

      // Requester 1 with a two-ones word
      dataV = setWord(dataV, 1, 8'h03);
      applyStimulus(4'b0010, dataV);
      drain();

      // All requesters held: rotation and back-to-back period after reset
      resetDut();
      for (int i = 0; i < NUM_REQ; i++) dataV = setWord(dataV, i, DATA_W'($urandom));
      repeat (5 * (DATA_W + 2)) applyStimulus(4'b1111, dataV);
      drain();

      // Reset in the fourth shift cycle, then the same request again
      dataV = setWord(dataV, 3, 8'hFF);
      applyStimulus(4'b1000, dataV);
      repeat (3) applyStimulus('0, dataV);
      resetDut();
      applyStimulus(4'b1000, dataV);
      drain();

      // Request dropped and word changed right after capture
      dataV = setWord(dataV, 0, 8'h07);
      applyStimulus(4'b0001, dataV);
      dataV = setWord(dataV, 0, 8'h0F);
      applyStimulus('0, dataV);
      drain();

      // Random traffic: new requesters join, winners sometimes drop and re-arm
      reqV = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            t = reqV >> i;
            if (!t[0] && $urandom_range(0, 7) == 0) begin
               dataV = setWord(dataV, i, DATA_W'($urandom));
               reqV  = reqV | (NUM_REQ'(1) << i);
            end
         end
         applyStimulus(reqV, dataV);
         if (capturedNow && $urandom_range(0, 1) == 0) begin
            reqV  = reqV & ~(NUM_REQ'(1) << capWinner);
            dataV = setWord(dataV, capWinner, DATA_W'($urandom));
         end
      end
      reqV = '0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
